mem_stage: RTL and testbench

- Pipeline memory stage, directly downstream of the execute stage.
- Takes the registered execute result (ALU value or effective address), the destination register, the store data and the instruction type.
- Performs load/store accesses on a single-port data-memory bus with a req/ack handshake, then presents the writeback result.
- Drives the memory-stage bypass pair (reg/val) back to execute and asserts a stall while an access is outstanding.

---
 rtl/mem_stage.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues load/store accesses on a req/ack data bus,
// aligns load data, drives writeback and the memory-stage bypass pair.
module mem_stage #(
  parameter int unsigned DMEM_TIMEOUT = 16,
  parameter logic [3:0]  L_TYPE       = 4'd1,
  parameter logic [3:0]  S_TYPE       = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_insn_type,
  input  logic [3:0]  ex_insn_sub_type,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_val,
  input  logic [31:0] ex_store_val,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  bp_mem_reg,
  output logic [31:0] bp_mem_val,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_val,
  output logic        wb_we,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Counter only needs to reach DMEM_TIMEOUT-1; the timeout fires on that value.
  localparam int unsigned    CW       = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0]  TMO_LAST = CW'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

  state_t         state_q, state_d;
  logic [CW-1:0]  tmo_cnt;
  logic [31:0]    req_addr;
  logic [4:0]     rd_q;
  logic [3:0]     sub_q;

  logic           is_load, is_store, is_mem, misaligned, tmo_hit;
  size_t          ex_size;
  logic [3:0]     be_d;
  logic [31:0]    wdata_d;
  logic [31:0]    ld_data;

  function automatic size_t size_of(input logic [3:0] sub);
    case (sub)
      4'd0, 4'd4: return SZ_B;
      4'd1, 4'd5: return SZ_H;
      default:    return SZ_W;
    endcase
  endfunction

  assign dmem_addr = {req_addr[31:2], 2'b00};

  // Request decode
  always_comb begin
    is_load    = (ex_insn_type == L_TYPE);
    is_store   = (ex_insn_type == S_TYPE);
    is_mem     = is_load || is_store;
    ex_size    = size_of(ex_insn_sub_type);
    misaligned = ((ex_size == SZ_H) && ex_val[0]) ||
                 ((ex_size == SZ_W) && (ex_val[1:0] != 2'b00));
    be_d    = 4'b1111;
    wdata_d = ex_store_val;
    if (is_store) begin
      case (ex_size)
        SZ_B: begin
          be_d    = 4'b0001 << ex_val[1:0];
          wdata_d = {4{ex_store_val[7:0]}};
        end
        SZ_H: begin
          be_d    = 4'b0011 << ex_val[1:0];
          wdata_d = {2{ex_store_val[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = ex_store_val;
        end
      endcase
    end
  end

  // Load lane selection and extension
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (req_addr[1:0])
      2'd0:    b = dmem_rdata[7:0];
      2'd1:    b = dmem_rdata[15:8];
      2'd2:    b = dmem_rdata[23:16];
      default: b = dmem_rdata[31:24];
    endcase
    h = req_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_of(sub_q))
      SZ_B:    ld_data = sub_q[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    ld_data = sub_q[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign tmo_hit = (state_q == ACCESS) && !dmem_ack &&
                   (DMEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ex_valid && is_mem && !misaligned) state_d = ACCESS;
      ACCESS: begin
        if (dmem_ack)     state_d = dmem_we ? IDLE : DONE;
        else if (tmo_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_stall = (state_q != IDLE) || (ex_valid && is_mem && !misaligned);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      req_addr   <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      bp_mem_reg <= '0;
      bp_mem_val <= '0;
      wb_rd      <= '0;
      wb_val     <= '0;
      wb_we      <= 1'b0;
      mem_fault  <= 1'b0;
      fault_addr <= '0;
      tmo_cnt    <= '0;
      rd_q       <= '0;
      sub_q      <= '0;
    end else begin
      wb_we     <= 1'b0;
      mem_fault <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_we      <= 1'b1;
              wb_rd      <= ex_rd;
              wb_val     <= ex_val;
              bp_mem_reg <= ex_rd;
              bp_mem_val <= ex_val;
            end else if (misaligned) begin
              mem_fault  <= 1'b1;
              fault_addr <= ex_val;
              bp_mem_reg <= '0;
              bp_mem_val <= '0;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              req_addr   <= ex_val;
              dmem_be    <= be_d;
              dmem_wdata <= wdata_d;
              rd_q       <= ex_rd;
              sub_q      <= ex_insn_sub_type;
              tmo_cnt    <= '0;
              bp_mem_reg <= '0;
              bp_mem_val <= '0;
            end
          end
        end
        ACCESS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              wb_we      <= 1'b1;
              wb_rd      <= rd_q;
              wb_val     <= ld_data;
              bp_mem_reg <= rd_q;
              bp_mem_val <= ld_data;
            end else begin
              bp_mem_reg <= '0;
              bp_mem_val <= '0;
            end
          end else if (tmo_hit) begin
            dmem_req   <= 1'b0;
            mem_fault  <= 1'b1;
            fault_addr <= req_addr;
            bp_mem_reg <= '0;
            bp_mem_val <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked against a
// byte-arithmetic model of load/store behaviour.
module tb_mem_stage;

  localparam int          TMO = 4;
  localparam logic [3:0]  LT  = 4'd1;
  localparam logic [3:0]  ST  = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_insn_type;
  logic [3:0]  ex_insn_sub_type;
  logic [4:0]  ex_rd;
  logic [31:0] ex_val;
  logic [31:0] ex_store_val;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  bp_mem_reg;
  logic [31:0] bp_mem_val;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        wb_we;
  logic        mem_stall;
  logic        mem_fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DMEM_TIMEOUT(TMO), .L_TYPE(LT), .S_TYPE(ST)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_insn_type(ex_insn_type),
    .ex_insn_sub_type(ex_insn_sub_type), .ex_rd(ex_rd), .ex_val(ex_val),
    .ex_store_val(ex_store_val), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .bp_mem_reg(bp_mem_reg),
    .bp_mem_val(bp_mem_val), .wb_rd(wb_rd), .wb_val(wb_val), .wb_we(wb_we),
    .mem_stall(mem_stall), .mem_fault(mem_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned op_bytes(input logic [3:0] sub);
    case (sub)
      4'd0, 4'd4: return 1;
      4'd1, 4'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [3:0] sub);
    int unsigned n = op_bytes(sub);
    logic [31:0] v = rdata >> (8 * (addr % 4));
    if (n < 4) begin
      v = v & ((32'd1 << (8 * n)) - 32'd1);
      if (sub < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    end
    return v;
  endfunction

  task automatic alu_op(input logic [3:0] t, input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    ex_valid = 1'b1; ex_insn_type = t; ex_insn_sub_type = 4'($urandom);
    ex_rd = rd; ex_val = val; ex_store_val = $urandom;
    #1 check("alu_stall", mem_stall, 0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("alu_wb_we", wb_we, 1);
    check("alu_wb_rd", wb_rd, rd);
    check("alu_wb_val", wb_val, val);
    check("alu_bp_reg", bp_mem_reg, rd);
    check("alu_bp_val", bp_mem_val, val);
    check("alu_req", dmem_req, 0);
    check("alu_stall2", mem_stall, 0);
    @(negedge clk);
    check("alu_wb_pulse", wb_we, 0);
    check("alu_bp_hold", bp_mem_reg, rd);
  endtask

  // ack_at: ACCESS cycle (1-based) in which ack is driven; 0 = never
  task automatic mem_op(input logic is_st, input logic [3:0] sub, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sval,
                        input logic [31:0] rdata, input int ack_at);
    int unsigned n  = op_bytes(sub);
    bit          ok = (addr % n) == 0;
    bit          acked = 1'b0;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld = load_result(rdata, addr, sub);
    be = is_st ? 4'(((32'd1 << n) - 32'd1) << (addr % 4)) : 4'hF;
    wd = !is_st ? 32'h0 : (n == 1) ? (sval & 32'hFF) * 32'h01010101 :
                          (n == 2) ? (sval & 32'hFFFF) * 32'h00010001 : sval;
    @(negedge clk);
    ex_valid = 1'b1; ex_insn_type = is_st ? ST : LT; ex_insn_sub_type = sub;
    ex_rd = rd; ex_val = addr; ex_store_val = sval;
    #1 check("issue_stall", mem_stall, 32'(ok));
    @(negedge clk);
    ex_valid = 1'b0;
    if (!ok) begin
      check("mis_fault", mem_fault, 1);
      check("mis_fault_addr", fault_addr, addr);
      check("mis_req", dmem_req, 0);
      check("mis_wb_we", wb_we, 0);
      check("mis_bp_reg", bp_mem_reg, 0);
      check("mis_stall", mem_stall, 0);
      @(negedge clk);
      check("mis_fault_pulse", mem_fault, 0);
      check("mis_fault_hold", fault_addr, addr);
      return;
    end
    for (int cyc = 1; cyc <= TMO; cyc++) begin
      check("acc_req", dmem_req, 1);
      check("acc_we", dmem_we, 32'(is_st));
      check("acc_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("acc_be", dmem_be, be);
      if (is_st) check("acc_wdata", dmem_wdata, wd);
      check("acc_stall", mem_stall, 1);
      check("acc_wb_we", wb_we, 0);
      check("acc_bp_reg", bp_mem_reg, 0);
      if (cyc == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      if (cyc == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      check("ack_req_drop", dmem_req, 0);
      check("ack_fault", mem_fault, 0);
      if (!is_st) begin
        check("ld_wb_we", wb_we, 1);
        check("ld_wb_rd", wb_rd, rd);
        check("ld_wb_val", wb_val, ld);
        check("ld_bp_reg", bp_mem_reg, rd);
        check("ld_bp_val", bp_mem_val, ld);
        check("ld_done_stall", mem_stall, 1);
        @(negedge clk);
        check("ld_wb_pulse", wb_we, 0);
        check("ld_stall_end", mem_stall, 0);
      end else begin
        check("st_wb_we", wb_we, 0);
        check("st_stall_end", mem_stall, 0);
        check("st_bp_reg", bp_mem_reg, 0);
      end
    end else begin
      check("tmo_req", dmem_req, 0);
      check("tmo_fault", mem_fault, 1);
      check("tmo_fault_addr", fault_addr, addr);
      check("tmo_wb_we", wb_we, 0);
      check("tmo_stall", mem_stall, 0);
      check("tmo_bp_reg", bp_mem_reg, 0);
      @(negedge clk);
      check("tmo_fault_pulse", mem_fault, 0);
    end
  endtask

  initial begin
    logic [3:0]  sub;
    logic [3:0]  t;
    logic [31:0] a;
    int          ack_at;
    bit          st;
    rst = 1'b1; ex_valid = 1'b0; ex_insn_type = '0; ex_insn_sub_type = '0;
    ex_rd = '0; ex_val = '0; ex_store_val = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_bp_reg", bp_mem_reg, 0);
    check("rst_bp_val", bp_mem_val, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_val", wb_val, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_fault_addr", fault_addr, 0);
    check("rst_stall", mem_stall, 0);
    rst = 1'b0;

    alu_op(4'd0, 5'd5, 32'h1234);
    mem_op(1'b0, 4'd0, 5'd3, 32'h103, 32'h0, 32'h80FF_FFFF, 3);
    mem_op(1'b0, 4'd4, 5'd3, 32'h103, 32'h0, 32'h80FF_FFFF, 3);
    mem_op(1'b1, 4'd1, 5'd0, 32'h202, 32'hABCD, 32'h0, 1);
    mem_op(1'b0, 4'd2, 5'd4, 32'h301, 32'h0, 32'h0, 1);
    mem_op(1'b0, 4'd2, 5'd6, 32'h400, 32'h0, 32'h0, 0);
    mem_op(1'b0, 4'd2, 5'd6, 32'h404, 32'h0, 32'hDEAD_BEEF, TMO);
    mem_op(1'b0, 4'd5, 5'd0, 32'h406, 32'h0, 32'h8001_7FFF, 2);
    alu_op(4'd3, 5'd0, 32'hCAFE_F00D);

    // Reset in the middle of an access, then a stray ack
    @(negedge clk);
    ex_valid = 1'b1; ex_insn_type = LT; ex_insn_sub_type = 4'd2; ex_rd = 5'd7; ex_val = 32'h500;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rstacc_req_before", dmem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstacc_req", dmem_req, 0);
    check("rstacc_wb_we", wb_we, 0);
    check("rstacc_bp_reg", bp_mem_reg, 0);
    check("rstacc_stall", mem_stall, 0);
    check("rstacc_fault_addr", fault_addr, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("stray_wb_we", wb_we, 0);
    check("stray_req", dmem_req, 0);
    check("stray_stall", mem_stall, 0);
    check("stray_bp_reg", bp_mem_reg, 0);
    check("stray_wb_val", wb_val, 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          t = 4'($urandom);
          if (t == LT || t == ST) t = 4'd0;
          alu_op(t, 5'($urandom), $urandom);
        end
        default: begin
          st = $urandom_range(0, 1) == 1;
          case ($urandom_range(0, st ? 2 : 4))
            0: sub = 4'd0; 1: sub = 4'd1; 2: sub = 4'd2; 3: sub = 4'd4; default: sub = 4'd5;
          endcase
          a = $urandom;
          if ($urandom_range(0, 3) != 0) a = a & ~(32'(op_bytes(sub)) - 32'd1);
          ack_at = $urandom_range(1, TMO);
          if ($urandom_range(0, 7) == 0) ack_at = 0;
          mem_op(st, sub, 5'($urandom), a, $urandom, $urandom, ack_at);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
